instrumentation_trip_latch: RTL and testbench

//  Sequential stage directly downstream of the combinational sensor-trip generator.
//  - Consumes the per-channel raw sensor-trip vector on each sample strobe.
//  - Debounces each channel over DEBOUNCE consecutive tripped samples.
//  - Applies the per-channel mode: bypass, operate or maintenance-trip.
//  - Latches the resulting trip until an operator reset.
//  - Presents registered trip bits plus an update strobe to the actuation voting logic.

---
 rtl/instrumentation_pkg.sv | 19 +
 rtl/trip_latch_channel.sv | 84 ++++++++
 rtl/instrumentation_trip_latch.sv | 45 ++++
 tb/tb_instrumentation_trip_latch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/instrumentation_pkg.sv
// rtl/instrumentation_pkg.sv - shared types for the instrumentation trip latch
package instrumentation_pkg;

  localparam int NUM_CHANNELS = 3;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'd0,
    MODE_OPERATE = 2'd1,
    MODE_MAINT   = 2'd2,
    MODE_RSVD    = 2'd3
  } trip_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_TRIPPED
  } latch_state_t;

endpackage

// File: rtl/trip_latch_channel.sv
// rtl/trip_latch_channel.sv - one channel: debounce counter, mode override and trip latch
module trip_latch_channel
  import instrumentation_pkg::*;
#(
  parameter int DEBOUNCE = 2,
  parameter int CNT_W    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic       sensor_trip,
  input  trip_mode_t mode,
  input  logic       reset_req,
  output logic       trip_out,
  output logic       pending
);

  localparam logic [CNT_W:0]   DEB_EXT = (CNT_W + 1)'(DEBOUNCE);
  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE);

  latch_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q;
  logic [CNT_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (mode)
      MODE_BYPASS: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      MODE_OPERATE: begin
        if (sample_valid && sensor_trip) begin
          // A tripped sample always beats a same-cycle operator reset.
          if (cnt_inc >= DEB_EXT) begin
            state_d = ST_TRIPPED;
            cnt_d   = DEB_CNT;
          end else begin
            state_d = (state_q == ST_TRIPPED) ? ST_TRIPPED : ST_PENDING;
            cnt_d   = cnt_inc[CNT_W-1:0];
          end
        end else if (state_q == ST_TRIPPED) begin
          // Reset only clears once the most recent accepted sample was clear.
          if (reset_req && !last_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (sample_valid) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        // Maintenance and reserved modes force the trip; the saturated count
        // keeps the latch consistent when the channel returns to operate.
        state_d = ST_TRIPPED;
        cnt_d   = DEB_CNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      trip_out <= 1'b0;
      pending  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      if (sample_valid) begin
        last_q <= sensor_trip;
      end
      trip_out <= (state_d == ST_TRIPPED);
      pending  <= (state_d == ST_PENDING);
    end
  end

endmodule

// File: rtl/instrumentation_trip_latch.sv
// rtl/instrumentation_trip_latch.sv - per-channel trip latches plus update strobe for voting logic
module instrumentation_trip_latch
  import instrumentation_pkg::*;
#(
  parameter int NChannels = NUM_CHANNELS,
  parameter int DEBOUNCE  = 2,
  parameter int CNT_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_valid,
  input  logic [NChannels-1:0]   sensor_trips,
  input  logic [2*NChannels-1:0] modes,
  input  logic [NChannels-1:0]   reset_req,
  output logic [NChannels-1:0]   trip_out,
  output logic                   trip_valid,
  output logic [NChannels-1:0]   pending
);

  for (genvar i = 0; i < NChannels; i++) begin : g_ch
    trip_latch_channel #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sensor_trip  (sensor_trips[i]),
      .mode         (trip_mode_t'(modes[2*i +: 2])),
      .reset_req    (reset_req[i]),
      .trip_out     (trip_out[i]),
      .pending      (pending[i])
    );
  end

  // Strobe lines up with the cycle in which trip_out reflects the sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trip_valid <= 1'b0;
    end else begin
      trip_valid <= sample_valid;
    end
  end

endmodule

// File: tb/tb_instrumentation_trip_latch.sv
// tb/tb_instrumentation_trip_latch.sv - directed and randomized bench with behavioural model
module tb_instrumentation_trip_latch;

  localparam int NCH = 3;
  localparam int DEB = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           sample_valid;
  logic [NCH-1:0] sensor_trips;
  logic [2*NCH-1:0] modes;
  logic [NCH-1:0] reset_req;
  logic [NCH-1:0] trip_out;
  logic           trip_valid;
  logic [NCH-1:0] pending;

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 1'b1;

  // Model: a latched flag, an unbounded run of consecutive tripped samples,
  // and the last accepted sample per channel.
  bit m_trip [NCH];
  int m_run  [NCH];
  bit m_last [NCH];
  bit m_tv;

  always #5 clk = ~clk;

  instrumentation_trip_latch #(
    .NChannels (NCH),
    .DEBOUNCE  (DEB),
    .CNT_W     (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sensor_trips (sensor_trips),
    .modes        (modes),
    .reset_req    (reset_req),
    .trip_out     (trip_out),
    .trip_valid   (trip_valid),
    .pending      (pending)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_trip[i] = 1'b0;
        m_run[i]  = 0;
        m_last[i] = 1'b0;
      end
      m_tv = 1'b0;
    end else begin
      m_tv = sample_valid;
      for (int i = 0; i < NCH; i++) begin
        int md;
        bit s;
        bit hit;
        md  = int'(modes[2*i +: 2]);
        s   = sensor_trips[i];
        hit = sample_valid && s;
        if (md == 0) begin
          m_trip[i] = 1'b0;
          m_run[i]  = 0;
        end else if (md >= 2) begin
          m_trip[i] = 1'b1;
        end else if (hit) begin
          m_run[i]++;
          if (m_run[i] >= DEB) m_trip[i] = 1'b1;
        end else if (m_trip[i]) begin
          if (reset_req[i] && !m_last[i]) begin
            m_trip[i] = 1'b0;
            m_run[i]  = 0;
          end
        end else if (sample_valid) begin
          m_run[i] = 0;
        end
        if (sample_valid) m_last[i] = s;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [NCH-1:0] exp_t, exp_p;
      for (int i = 0; i < NCH; i++) begin
        exp_t[i] = m_trip[i];
        exp_p[i] = !m_trip[i] && (m_run[i] > 0);
      end
      chk("model_trip_out", 32'(trip_out), 32'(exp_t));
      chk("model_pending", 32'(pending), 32'(exp_p));
      chk("model_trip_valid", 32'(trip_valid), 32'(m_tv));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic sv, input logic [NCH-1:0] trips, input logic [NCH-1:0] rr);
    sample_valid = sv;
    sensor_trips = trips;
    reset_req    = rr;
    tick();
    sample_valid = 1'b0;
    reset_req    = '0;
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b1;
    sensor_trips = 3'b111;
    modes        = 6'b010101;
    reset_req    = '0;
    repeat (3) tick();
    chk("reset_trip_out", 32'(trip_out), 0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_trip_valid", 32'(trip_valid), 0);
    rst_n        = 1'b1;
    sample_valid = 1'b0;
    sensor_trips = '0;

    // Debounce on ch0
    drive(1'b1, 3'b001, 3'b000);
    chk("deb_pending0", 32'(pending[0]), 1);
    chk("deb_trip0_early", 32'(trip_out[0]), 0);
    drive(1'b1, 3'b001, 3'b000);
    chk("deb_trip0", 32'(trip_out[0]), 1);
    chk("deb_pending0_clr", 32'(pending[0]), 0);
    drive(1'b1, 3'b000, 3'b000);
    drive(1'b0, 3'b000, 3'b001);
    chk("deb_clear0", 32'(trip_out[0]), 0);
    drive(1'b1, 3'b001, 3'b000);
    drive(1'b1, 3'b000, 3'b000);
    drive(1'b1, 3'b001, 3'b000);
    chk("deb_101_no_trip", 32'(trip_out[0]), 0);
    drive(1'b1, 3'b000, 3'b000);

    // Latch and operator reset on ch1
    drive(1'b1, 3'b010, 3'b000);
    drive(1'b1, 3'b010, 3'b000);
    chk("latch_trip1", 32'(trip_out[1]), 1);
    drive(1'b0, 3'b000, 3'b010);
    chk("latch_reset_dropped", 32'(trip_out[1]), 1);
    drive(1'b1, 3'b000, 3'b000);
    drive(1'b0, 3'b000, 3'b010);
    chk("latch_reset_ok", 32'(trip_out[1]), 0);

    // Simultaneous reset and tripped sample on ch2
    drive(1'b1, 3'b100, 3'b000);
    drive(1'b1, 3'b100, 3'b000);
    drive(1'b1, 3'b100, 3'b100);
    chk("simul_trip_wins", 32'(trip_out[2]), 1);
    drive(1'b1, 3'b000, 3'b000);
    drive(1'b0, 3'b000, 3'b100);
    chk("simul_cleanup", 32'(trip_out[2]), 0);

    // Modes on ch0
    modes = 6'b010110;
    tick();
    chk("mode2_forces", 32'(trip_out[0]), 1);
    modes = 6'b010101;
    tick();
    chk("mode1_keeps", 32'(trip_out[0]), 1);
    drive(1'b1, 3'b000, 3'b000);
    drive(1'b0, 3'b000, 3'b001);
    chk("mode1_reset", 32'(trip_out[0]), 0);
    modes = 6'b010100;
    drive(1'b1, 3'b111, 3'b000);
    drive(1'b1, 3'b111, 3'b000);
    chk("mode0_bypass", 32'(trip_out[0]), 0);
    modes = 6'b010111;
    tick();
    chk("mode3_forces", 32'(trip_out[0]), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    modes = 6'b010101;

    // Strobe timing and mid-count reset
    drive(1'b1, 3'b000, 3'b000);
    chk("strobe_first", 32'(trip_valid), 1);
    tick();
    chk("strobe_gap", 32'(trip_valid), 0);
    tick();
    tick();
    drive(1'b1, 3'b000, 3'b000);
    chk("strobe_second", 32'(trip_valid), 1);
    drive(1'b1, 3'b001, 3'b000);
    chk("midrst_pending", 32'(pending[0]), 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_pending_clr", 32'(pending[0]), 0);
    rst_n = 1'b1;
    drive(1'b1, 3'b001, 3'b000);
    chk("midrst_no_trip", 32'(trip_out[0]), 0);

    // Randomized phase, checked every cycle by the model comparison
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      sample_valid = 1'($urandom_range(0, 1));
      sensor_trips = 3'($urandom);
      reset_req    = 3'($urandom);
      for (int i = 0; i < NCH; i++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 14)      modes[2*i +: 2] = 2'd1;
        else if (r < 16) modes[2*i +: 2] = 2'd0;
        else if (r < 18) modes[2*i +: 2] = 2'd2;
        else             modes[2*i +: 2] = 2'd3;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
